// File: rtl/serialtx_fifo_pkg.sv
// Shared types and register map for the buffered UART transmitter.
package serial_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  localparam logic [1:0] REG_DATA  = 2'd0;
  localparam logic [1:0] REG_DIV   = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_COUNT = 2'd3;

  // Encoding 3 is reserved and behaves as no parity.
  function automatic parity_t decode_parity(input logic [1:0] v);
    case (v)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/serialtx_fifo_sync_fifo.sv
// Single-clock FIFO with show-ahead head output; pointers carry an extra wrap bit.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/serialtx_fifo.sv
// Wishbone-attached UART transmitter with TX FIFO, programmable divisor,
// optional parity, 1/2 stop bits and a clearable completed-frame counter.
module serialtx_fifo
  import serial_pkg::*;
#(
  parameter int unsigned FRAME     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned DIV_INIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        uart_tx,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data_w,
  output logic [31:0] wb_data_r,
  input  logic        wb_we,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  output logic        wb_ack,
  output logic        wb_stall,
  output logic        tx_empty
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = (FRAME > 1) ? $clog2(FRAME) : 1;

  logic                 req, accept, push, pop, wr_en;
  logic [1:0]           reg_sel;
  logic                 fifo_full, fifo_empty;
  logic [LW-1:0]        fifo_level;
  logic [FRAME-1:0]     fifo_head;
  logic [DIV_WIDTH-1:0] div_q, wdiv;
  logic [2:0]           ctrl_q;
  logic [31:0]          count_q, rdata_d, rdata_q;
  logic                 ack_q;
  parity_t              ctrl_par;

  tx_state_t            state_q;
  logic [DIV_WIDTH-1:0] cnt_q, div_s_q;
  logic [BW-1:0]        bit_q;
  logic [FRAME-1:0]     shift_q;
  logic                 stop_q, stop2_q, par_en_q, par_bit_q, tx_q;
  logic                 bit_end, stop_last, frame_done;

  logic                 unused_ok;
  assign unused_ok = ^{wb_addr, wb_data_w};

  assign reg_sel  = wb_addr[3:2];
  assign req      = wb_cyc && wb_stb;
  assign wb_stall = req && wb_we && (reg_sel == REG_DATA) && fifo_full;
  assign accept   = req && !wb_stall;
  assign wr_en    = accept && wb_we;
  assign push     = wr_en && (reg_sel == REG_DATA);
  assign wdiv     = wb_data_w[DIV_WIDTH-1:0];
  assign ctrl_par = decode_parity(ctrl_q[1:0]);

  assign wb_ack    = ack_q;
  assign wb_data_r = rdata_q;
  assign uart_tx   = tx_q;
  assign tx_empty  = fifo_empty && (state_q == TX_IDLE);

  sync_fifo #(.WIDTH(FRAME), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i (wb_data_w[FRAME-1:0]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    rdata_d = '0;
    if (accept && !wb_we) begin
      case (reg_sel)
        REG_DATA:  rdata_d = 32'(fifo_level);
        REG_DIV:   rdata_d = 32'(div_q);
        REG_CTRL:  rdata_d = {29'd0, ctrl_q};
        default:   rdata_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= DIV_WIDTH'(DIV_INIT);
      ctrl_q  <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= accept;
      rdata_q <= rdata_d;
      if (wr_en && reg_sel == REG_DIV)  div_q  <= (wdiv == '0) ? DIV_WIDTH'(1) : wdiv;
      if (wr_en && reg_sel == REG_CTRL) ctrl_q <= wb_data_w[2:0];
      // A clear wins over a completion landing in the same cycle.
      if (wr_en && reg_sel == REG_COUNT) count_q <= '0;
      else if (frame_done)               count_q <= count_q + 32'd1;
    end
  end

  assign bit_end    = (cnt_q == div_s_q - DIV_WIDTH'(1));
  assign stop_last  = (stop_q == stop2_q);
  assign frame_done = (state_q == TX_STOP) && bit_end && stop_last;
  assign pop        = !fifo_empty && ((state_q == TX_IDLE) || frame_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      div_s_q   <= DIV_WIDTH'(1);
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (pop) begin
      // Covers both the idle start and the back-to-back start out of STOP.
      state_q   <= TX_START;
      cnt_q     <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b0;
      shift_q   <= fifo_head;
      div_s_q   <= div_q;
      par_en_q  <= (ctrl_par != PAR_NONE);
      par_bit_q <= (^fifo_head) ^ (ctrl_par == PAR_ODD);
      stop2_q   <= ctrl_q[2];
    end else begin
      if (state_q != TX_IDLE) cnt_q <= bit_end ? '0 : cnt_q + DIV_WIDTH'(1);
      case (state_q)
        TX_IDLE: tx_q <= 1'b1;
        TX_START: if (bit_end) begin
          state_q <= TX_DATA;
          tx_q    <= shift_q[0];
        end
        TX_DATA: if (bit_end) begin
          if (bit_q == BW'(FRAME-1)) begin
            bit_q   <= '0;
            state_q <= par_en_q ? TX_PARITY : TX_STOP;
            tx_q    <= par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_q   <= bit_q + BW'(1);
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
          end
        end
        TX_PARITY: if (bit_end) begin
          state_q <= TX_STOP;
          tx_q    <= 1'b1;
        end
        TX_STOP: if (bit_end) begin
          if (stop_last) state_q <= TX_IDLE;
          else           stop_q  <= 1'b1;
        end
        default: begin
          state_q <= TX_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serialtx_fifo.sv
// Directed bench for serialtx_fifo: frame vectors from a table, then burst,
// stall, reset and bus corner cases.
module tb_serialtx_fifo;
  import serial_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_tx;
  logic [31:0] wb_addr, wb_data_w, wb_data_r;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_stall, tx_empty;

  always #5 clk = ~clk;

  serialtx_fifo #(.FRAME(8), .DEPTH(DEPTH), .DIV_WIDTH(16), .DIV_INIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_tx   (uart_tx),
    .wb_addr   (wb_addr),
    .wb_data_w (wb_data_w),
    .wb_data_r (wb_data_r),
    .wb_we     (wb_we),
    .wb_stb    (wb_stb),
    .wb_cyc    (wb_cyc),
    .wb_ack    (wb_ack),
    .wb_stall  (wb_stall),
    .tx_empty  (tx_empty)
  );

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned cyc_n = 0, ack_cnt = 0;
  logic        tx_log [4096];

  always @(posedge clk) begin
    #2;
    if (cyc_n < 4096) tx_log[cyc_n] = uart_tx;
    cyc_n++;
    if (wb_ack) ack_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                         input string nm, output logic [31:0] rd);
    int unsigned n = 0;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_addr = {28'd0, a, 2'b00}; wb_data_w = d;
    #1;
    while (wb_stall && n < 500) begin
      @(negedge clk); #1; n++;
    end
    check({nm, "_stall"}, 32'(wb_stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    check({nm, "_ack"}, 32'(wb_ack), 32'd1);
    rd = wb_data_r;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(1'b1, a, d, "wr", rd);
  endtask

  task automatic wb_read_chk(input logic [1:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] rd;
    wb_xfer(1'b0, a, 32'd0, nm, rd);
    check(nm, rd, exp);
  endtask

  typedef struct {
    logic [15:0] div;
    logic [2:0]  ctrl;
    logic [7:0]  data;
    int unsigned len;    // frame length in clk cycles
    logic [15:0] bits;   // line level per bit period, first period in bit 0
  } vec_t;

  vec_t vecs [5];

  initial begin
    int unsigned base, n, guard, f, bp;
    int unsigned stalls [6];
    int unsigned ack_base;
    logic [7:0]  d;
    logic        exp, saw_low;

    vecs[0] = '{16'd2, 3'd0, 8'h55, 20, 16'h02AA};  // 8N1
    vecs[1] = '{16'd4, 3'd1, 8'h07, 44, 16'h060E};  // even parity = 1
    vecs[2] = '{16'd4, 3'd6, 8'h00, 48, 16'h0E00};  // odd parity = 1, 2 stop
    vecs[3] = '{16'd3, 3'd2, 8'hA5, 33, 16'h074A};  // odd parity = 1
    vecs[4] = '{16'd1, 3'd3, 8'hFF, 10, 16'h03FE};  // parity code 3 -> none

    rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_addr = '0; wb_data_w = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_stall", 32'(wb_stall), 32'd0);
    check("rst_rdata", wb_data_r, 32'd0);
    check("rst_tx_empty", 32'(tx_empty), 32'd1);
    rst = 1'b0;
    wb_read_chk(REG_DIV, 32'd2, "rst_div");
    wb_read_chk(REG_CTRL, 32'd0, "rst_ctrl");
    wb_read_chk(REG_COUNT, 32'd0, "rst_count");
    wb_read_chk(REG_DATA, 32'd0, "rst_level");

    for (int i = 0; i < 5; i++) begin
      wb_write(REG_DIV, 32'(vecs[i].div));
      wb_write(REG_CTRL, 32'(vecs[i].ctrl));
      wb_write(REG_DATA, 32'(vecs[i].data));
      for (int unsigned k = 0; k < vecs[i].len; k++) begin
        @(negedge clk);
        exp = vecs[i].bits[k / 32'(vecs[i].div)];
        check($sformatf("v%0d_tx%0d", i, k), 32'(uart_tx), 32'(exp));
      end
      @(negedge clk);
      check($sformatf("v%0d_idle_tx", i), 32'(uart_tx), 32'd1);
      check($sformatf("v%0d_tx_empty", i), 32'(tx_empty), 32'd1);
      wb_read_chk(REG_COUNT, 32'(i + 1), $sformatf("v%0d_count", i));
    end

    wb_write(REG_CTRL, 32'hFFFF_FFFF);
    wb_read_chk(REG_CTRL, 32'd7, "ctrl_mask");
    wb_write(REG_DIV, 32'd0);
    wb_read_chk(REG_DIV, 32'd1, "div_zero");

    wb_write(REG_COUNT, 32'd0);
    wb_read_chk(REG_COUNT, 32'd0, "count_clear");
    wb_write(REG_DIV, 32'd2);
    wb_write(REG_CTRL, 32'd0);
    ack_base = ack_cnt;

    // The first byte is popped the cycle after it lands, so DEPTH+2 pushes
    // are needed before one actually stalls.
    @(negedge clk);
    for (int i = 0; i < DEPTH + 2; i++) begin
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
      wb_addr = {28'd0, REG_DATA, 2'b00}; wb_data_w = 32'h30 + 32'(i);
      #1;
      if (i == 0) base = cyc_n;
      n = 0;
      while (wb_stall && n < 200) begin
        @(negedge clk); #1; n++;
      end
      stalls[i] = n;
      @(negedge clk);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      check($sformatf("burst_nostall%0d", i), stalls[i], 32'd0);
    check("burst_stall_cycles", stalls[DEPTH + 1], 32'd17);

    guard = 0;
    while (cyc_n < base + 124 && guard < 1000) begin
      @(negedge clk); guard++;
    end
    check("burst_wait", 32'(cyc_n >= base + 124), 32'd1);
    check("burst_acks", ack_cnt - ack_base, 32'(DEPTH + 2));
    for (int unsigned k = 0; k < 120; k++) begin
      f  = k / 20;
      bp = (k % 20) / 2;
      d  = 8'h30 + 8'(f);
      exp = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : d[bp-1];
      check($sformatf("stream_tx%0d", k), 32'(tx_log[base + 1 + k]), 32'(exp));
    end
    check("stream_idle", 32'(tx_log[base + 121]), 32'd1);
    check("burst_tx_empty", 32'(tx_empty), 32'd1);
    wb_read_chk(REG_COUNT, 32'(DEPTH + 2), "burst_count");

    wb_write(REG_DIV, 32'd3);
    wb_write(REG_CTRL, 32'd5);
    wb_write(REG_DATA, 32'hAA);
    wb_write(REG_DATA, 32'h11);
    wb_write(REG_DATA, 32'h22);
    check("pre_reset_tx", 32'(uart_tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_reset_tx", 32'(uart_tx), 32'd1);
    check("post_reset_tx_empty", 32'(tx_empty), 32'd1);
    wb_read_chk(REG_DATA, 32'd0, "post_reset_level");
    wb_read_chk(REG_COUNT, 32'd0, "post_reset_count");
    wb_read_chk(REG_DIV, 32'd2, "post_reset_div");
    wb_read_chk(REG_CTRL, 32'd0, "post_reset_ctrl");
    saw_low = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!uart_tx) saw_low = 1'b1;
    end
    check("post_reset_line_idle", 32'(saw_low), 32'd0);

    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b1; wb_we = 1'b0;
    wb_addr = {28'd0, REG_DIV, 2'b00};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("nocyc_ack%0d", i), 32'(wb_ack), 32'd0);
    end
    check("nocyc_stall", 32'(wb_stall), 32'd0);
    wb_stb = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
